// File: rtl/xadc_sampler_pkg.sv
// xadc_sampler_pkg: shared types and constants for the XADC sampling controller.
//   state_e         : sequencing FSM states
//   DRP_ADDR_W/_DATA: DRP bus widths
//   VAUX0_ADDR      : DRP status address of auxiliary channel 0
//   DEFAULT_CLK_DIV : 50 MHz / 16 kHz sample-tick divider
package xadc_sampler_pkg;

  localparam int DRP_ADDR_W      = 7;
  localparam int DRP_DATA_W      = 16;
  localparam int DEFAULT_CLK_DIV = 3125;

  localparam logic [DRP_ADDR_W-1:0] VAUX0_ADDR = 7'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_EOC,
    ST_READ,
    ST_WAIT_DRDY
  } state_e;

endpackage

// File: rtl/xadc_sample_fifo.sv
// xadc_sample_fifo: first-word-fall-through sample FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   pop        : consume the head entry (ignored when empty)
//   rd_data    : head entry, forced to 0 while empty
//   full/empty : occupancy flags; level: current occupancy
//   drop       : one-cycle pulse when a push is refused because the FIFO is full
module xadc_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    do_pop  = pop && (level_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push && ((level_q != LVL_W'(DEPTH)) || do_pop);

    // Pointers are power-of-two wide, so they wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  // NOTE: the storage array is deliberately not reset; the level counter alone
  // decides which entries are meaningful, and rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign level   = level_q;
  assign drop    = push && !do_push;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/xadc_sampler.sv
// xadc_sampler: fixed-rate XADC conversion controller (event-driven, single channel).
//   dclk_in, reset_n_in        : DRP clock, asynchronous active-low reset
//   enable_in                  : run the sample-rate divider
//   status_clr_in              : clears the sticky flags (a same-cycle set wins)
//   convst_out, busy_in, eoc_in, channel_in : XADC conversion handshake
//   den_out, dwe_out, daddr_out, di_out, drdy_in, do_in : DRP master (read only)
//   sample_out, sample_valid_out, sample_ready_in, fifo_level_out : sample stream
//   overrun_out, missed_tick_out, timeout_out : sticky status flags
// Build option: define XADC_SAMPLER_SIGNED_EN to store samples as two's complement
// (MSB inverted at FIFO write); otherwise samples stay offset binary.
module xadc_sampler
  import xadc_sampler_pkg::*;
#(
  parameter int CLK_DIV      = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int SAMPLE_W     = 12
) (
  input  logic                        dclk_in,
  input  logic                        reset_n_in,
  input  logic                        enable_in,
  input  logic                        status_clr_in,
  output logic                        convst_out,
  input  logic                        busy_in,
  input  logic                        eoc_in,
  input  logic [4:0]                  channel_in,
  output logic                        den_out,
  output logic                        dwe_out,
  output logic [DRP_ADDR_W-1:0]       daddr_out,
  output logic [DRP_DATA_W-1:0]       di_out,
  input  logic                        drdy_in,
  input  logic [DRP_DATA_W-1:0]       do_in,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        sample_valid_out,
  input  logic                        sample_ready_in,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
  output logic                        overrun_out,
  output logic                        missed_tick_out,
  output logic                        timeout_out
);

  localparam int TO_W = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  // The den_out cycle counts as the first cycle of the wait window, so the
  // counter (cleared in READ) fires two short of DRDY_TIMEOUT and timeout_out
  // rises exactly DRDY_TIMEOUT cycles after den_out.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRDY_TIMEOUT - 2);

  state_e                state_q, state_d;
  logic [15:0]           div_cnt_q, div_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [DRP_ADDR_W-1:0] daddr_q, daddr_d;
  logic                  convst_q, convst_d;
  logic                  den_q, den_d;
  logic                  overrun_q, overrun_d;
  logic                  missed_q, missed_d;
  logic                  timeout_q, timeout_d;
  logic                  tick, push, timeout_set, missed_set;
  logic [SAMPLE_W-1:0]   push_data;
  logic                  fifo_empty, fifo_drop;
  logic                  unused_fifo_full;
  logic                  unused_do_lsbs;

  assign unused_do_lsbs = ^do_in[DRP_DATA_W-SAMPLE_W-1:0];

  always_comb begin
    state_d     = state_q;
    daddr_d     = daddr_q;
    to_cnt_d    = to_cnt_q;
    push        = 1'b0;
    timeout_set = 1'b0;

    // Sample-rate divider: held at 0 while disabled, one-cycle tick at the top.
    tick = enable_in && (div_cnt_q == DIV_LAST);
    if (!enable_in || tick) div_cnt_d = '0;
    else                    div_cnt_d = div_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE:      if (tick && !busy_in) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_EOC;
      ST_WAIT_EOC: begin
        if (eoc_in) begin
          daddr_d = {{(DRP_ADDR_W-5){1'b0}}, channel_in};
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (drdy_in) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default:      state_d = ST_IDLE;
    endcase

    // Any tick that cannot start a conversion is reported, never queued.
    missed_set = tick && ((state_q != ST_IDLE) || busy_in);

    // Pulses are registered copies of the state they belong to.
    convst_d = (state_d == ST_START);
    den_d    = (state_d == ST_READ);

    overrun_d = fifo_drop   || (overrun_q && !status_clr_in);
    missed_d  = missed_set  || (missed_q  && !status_clr_in);
    timeout_d = timeout_set || (timeout_q && !status_clr_in);

    push_data = do_in[DRP_DATA_W-1 -: SAMPLE_W];
`ifdef XADC_SAMPLER_SIGNED_EN
    push_data[SAMPLE_W-1] = ~push_data[SAMPLE_W-1];
`endif
  end

  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      to_cnt_q  <= '0;
      daddr_q   <= '0;
      convst_q  <= 1'b0;
      den_q     <= 1'b0;
      overrun_q <= 1'b0;
      missed_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      to_cnt_q  <= to_cnt_d;
      daddr_q   <= daddr_d;
      convst_q  <= convst_d;
      den_q     <= den_d;
      overrun_q <= overrun_d;
      missed_q  <= missed_d;
      timeout_q <= timeout_d;
    end
  end

  xadc_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (dclk_in),
    .rst_n     (reset_n_in),
    .push      (push),
    .push_data (push_data),
    .pop       (sample_ready_in),
    .rd_data   (sample_out),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_out),
    .drop      (fifo_drop)
  );

  assign sample_valid_out = !fifo_empty;
  assign convst_out       = convst_q;
  assign den_out          = den_q;
  assign daddr_out        = daddr_q;
  assign dwe_out          = 1'b0;
  assign di_out           = '0;
  assign overrun_out      = overrun_q;
  assign missed_tick_out  = missed_q;
  assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_xadc_sampler.sv
// tb_xadc_sampler: directed self-checking bench for xadc_sampler with a
// behavioural XADC/DRP responder (CLK_DIV=100, FIFO_DEPTH=8, DRDY_TIMEOUT=255).
module tb_xadc_sampler;

  localparam int CLK_DIV = 100;
  localparam int DEPTH   = 8;
  localparam int TMO     = 255;

  localparam int EV_CONVST = 0, EV_DEN = 1, EV_EOC = 2, EV_DRDY = 3,
                 EV_VRISE = 4, EV_TO = 5;

  logic        dclk_in = 1'b0;
  logic        reset_n_in;
  logic        enable_in;
  logic        status_clr_in;
  logic        convst_out;
  logic        busy_in;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        den_out;
  logic        dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic        drdy_in;
  logic [15:0] do_in;
  logic [11:0] sample_out;
  logic        sample_valid_out;
  logic        sample_ready_in;
  logic [3:0]  fifo_level_out;
  logic        overrun_out;
  logic        missed_tick_out;
  logic        timeout_out;

  xadc_sampler #(
    .CLK_DIV      (CLK_DIV),
    .FIFO_DEPTH   (DEPTH),
    .DRDY_TIMEOUT (TMO),
    .SAMPLE_W     (12)
  ) dut (
    .dclk_in          (dclk_in),
    .reset_n_in       (reset_n_in),
    .enable_in        (enable_in),
    .status_clr_in    (status_clr_in),
    .convst_out       (convst_out),
    .busy_in          (busy_in),
    .eoc_in           (eoc_in),
    .channel_in       (channel_in),
    .den_out          (den_out),
    .dwe_out          (dwe_out),
    .daddr_out        (daddr_out),
    .di_out           (di_out),
    .drdy_in          (drdy_in),
    .do_in            (do_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .sample_ready_in  (sample_ready_in),
    .fifo_level_out   (fifo_level_out),
    .overrun_out      (overrun_out),
    .missed_tick_out  (missed_tick_out),
    .timeout_out      (timeout_out)
  );

  always #5 dclk_in = ~dclk_in;

  // Every output concatenated, for the all-zero reset comparisons.
  logic [45:0] all_outs;
  assign all_outs = {convst_out, den_out, dwe_out, daddr_out, di_out, sample_out,
                     sample_valid_out, fifo_level_out, overrun_out,
                     missed_tick_out, timeout_out};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rel_cyc = 0;

  // Model configuration and event log (cycle stamps).
  int          eoc_delay = 5;
  int          drdy_delay = 2;
  bit          drdy_never = 1'b0;
  int          eoc_cnt = -1;
  int          drdy_cnt = -1;
  logic        prev_valid = 1'b0;
  logic        prev_to = 1'b0;
  logic [6:0]  den_addr = '0;
  logic [15:0] data_q [$];
  int convst_t [$];
  int den_t [$];
  int eoc_t [$];
  int drdy_t [$];
  int vrise_t [$];
  int to_t [$];

  function automatic logic [11:0] exp_sample(input logic [15:0] raw);
    logic [11:0] s;
    s = raw[15:4];
`ifdef XADC_SAMPLER_SIGNED_EN
    s[11] = ~s[11];
`endif
    return s;
  endfunction

  function automatic int qsize(input int which);
    case (which)
      EV_CONVST: return convst_t.size();
      EV_DEN:    return den_t.size();
      EV_EOC:    return eoc_t.size();
      EV_DRDY:   return drdy_t.size();
      EV_VRISE:  return vrise_t.size();
      default:   return to_t.size();
    endcase
  endfunction

  // Behavioural XADC + DRP slave and event monitor; runs 1 time unit after
  // each rising edge, the bench tasks act 2 units after it.
  initial begin : xadc_model
    busy_in = 1'b0; eoc_in = 1'b0; drdy_in = 1'b0; do_in = '0; channel_in = 5'h10;
    forever begin
      @(posedge dclk_in); #1;
      cyc++;
      eoc_in  = 1'b0;
      drdy_in = 1'b0;
      if (sample_valid_out && !prev_valid) vrise_t.push_back(cyc);
      if (timeout_out && !prev_to)         to_t.push_back(cyc);
      prev_valid = sample_valid_out;
      prev_to    = timeout_out;
      if (!reset_n_in) begin
        busy_in = 1'b0; eoc_cnt = -1; drdy_cnt = -1;
      end else begin
        if (convst_out) begin
          convst_t.push_back(cyc); busy_in = 1'b1; eoc_cnt = eoc_delay;
        end
        if (den_out) begin
          den_t.push_back(cyc); den_addr = daddr_out;
          drdy_cnt = drdy_never ? -1 : drdy_delay;
        end
        if (eoc_cnt == 0) begin
          eoc_in = 1'b1; busy_in = 1'b0; eoc_t.push_back(cyc); eoc_cnt = -1;
        end else if (eoc_cnt > 0) begin
          eoc_cnt--;
        end
        if (drdy_cnt == 0) begin
          drdy_in = 1'b1;
          if (data_q.size() > 0) do_in = data_q.pop_front();
          else                   do_in = 16'hABC0;
          drdy_t.push_back(cyc); drdy_cnt = -1;
        end else if (drdy_cnt > 0) begin
          drdy_cnt--;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge dclk_in); #2;
  endtask

  task automatic wait_evt(input int which, input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (qsize(which) >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (qsize(which) >= n) ok = 1'b1;
  endtask

  // Holds reset, clears the event log, releases 2 units after an edge.
  task automatic do_reset();
    reset_n_in = 1'b0;
    repeat (3) step();
    convst_t.delete(); den_t.delete(); eoc_t.delete();
    drdy_t.delete(); vrise_t.delete(); to_t.delete(); data_q.delete();
    @(posedge dclk_in); #2;
    reset_n_in = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_reset();
    enable_in = 1'b0; status_clr_in = 1'b0; sample_ready_in = 1'b0;
    reset_n_in = 1'b0;
    #3;
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++; $display("FAIL reset_outputs_low: got %h want 0", all_outs);
    end
    do_reset();
    repeat (2 * CLK_DIV + 10) step();
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++; $display("FAIL reset_idle_outputs: got %h want 0", all_outs);
    end
    n_cmp++;
    if (convst_t.size() != 0) begin
      n_bad++; $display("FAIL disabled_no_convst: got %0d pulses want 0", convst_t.size());
    end
  endtask

  task automatic test_basic();
    bit ok;
    enable_in = 1'b1; sample_ready_in = 1'b0; drdy_never = 1'b0;
    eoc_delay = 5; drdy_delay = 2;
    do_reset();
    wait_evt(EV_CONVST, 2, 3 * CLK_DIV, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_convst_seen: got %0d want 2", convst_t.size()); end
    n_cmp++;
    if (convst_t[0] - rel_cyc != CLK_DIV) begin
      n_bad++; $display("FAIL basic_first_convst: got %0d want %0d", convst_t[0] - rel_cyc, CLK_DIV);
    end
    n_cmp++;
    if (convst_t[1] - convst_t[0] != CLK_DIV) begin
      n_bad++; $display("FAIL basic_convst_period: got %0d want %0d", convst_t[1] - convst_t[0], CLK_DIV);
    end
    n_cmp++;
    if (den_t.size() < 1 || den_addr !== 7'h10) begin
      n_bad++; $display("FAIL basic_daddr: got %h want 10", den_addr);
    end
    n_cmp++;
    if (den_t[0] - eoc_t[0] != 1) begin
      n_bad++; $display("FAIL basic_eoc_to_den: got %0d want 1", den_t[0] - eoc_t[0]);
    end
    n_cmp++;
    if (vrise_t.size() < 1 || vrise_t[0] - drdy_t[0] != 1) begin
      n_bad++; $display("FAIL basic_drdy_to_valid: got %0d want 1", vrise_t[0] - drdy_t[0]);
    end
    n_cmp++;
    if (sample_out !== exp_sample(16'hABC0) || sample_valid_out !== 1'b1) begin
      n_bad++; $display("FAIL basic_sample: got %h/%b want %h/1", sample_out, sample_valid_out,
                        exp_sample(16'hABC0));
    end
  endtask

  task automatic test_codes();
    bit ok;
    logic [11:0] exp_v [3];
`ifdef XADC_SAMPLER_SIGNED_EN
    exp_v[0] = 12'h000; exp_v[1] = 12'h800; exp_v[2] = 12'h7FF;
`else
    exp_v[0] = 12'h800; exp_v[1] = 12'h000; exp_v[2] = 12'hFFF;
`endif
    enable_in = 1'b1; sample_ready_in = 1'b0; drdy_never = 1'b0;
    do_reset();
    data_q.push_back(16'h8000); data_q.push_back(16'h0000); data_q.push_back(16'hFFF0);
    wait_evt(EV_DRDY, 3, 4 * CLK_DIV, ok);
    step();
    enable_in = 1'b0;
    n_cmp++;
    if (!ok || fifo_level_out !== 4'd3) begin
      n_bad++; $display("FAIL codes_level: got %0d want 3", fifo_level_out);
    end
    sample_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (sample_out !== exp_v[i] || sample_valid_out !== 1'b1) begin
        n_bad++; $display("FAIL codes_sample%0d: got %h want %h", i, sample_out, exp_v[i]);
      end
      step();
    end
    sample_ready_in = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    logic [15:0] raw [10];
    enable_in = 1'b1; sample_ready_in = 1'b0; drdy_never = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      raw[k] = {12'h100 + 12'(k), 4'h0};
      data_q.push_back(raw[k]);
    end
    wait_evt(EV_DRDY, 8, 9 * CLK_DIV, ok);
    step();
    n_cmp++;
    if (!ok || fifo_level_out !== 4'd8 || overrun_out !== 1'b0) begin
      n_bad++; $display("FAIL overrun_full_no_flag: got level %0d ovr %b want 8 0",
                        fifo_level_out, overrun_out);
    end
    wait_evt(EV_DRDY, 9, 2 * CLK_DIV, ok);
    step();
    n_cmp++;
    if (!ok || overrun_out !== 1'b1 || fifo_level_out !== 4'd8) begin
      n_bad++; $display("FAIL overrun_9th: got ovr %b level %0d want 1 8", overrun_out, fifo_level_out);
    end
    wait_evt(EV_DRDY, 10, 2 * CLK_DIV, ok);
    step();
    enable_in = 1'b0;
    n_cmp++;
    if (!ok || fifo_level_out !== 4'd8) begin
      n_bad++; $display("FAIL overrun_10th_level: got %0d want 8", fifo_level_out);
    end
    sample_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sample_out !== exp_sample(raw[i]) || sample_valid_out !== 1'b1) begin
        n_bad++; $display("FAIL overrun_pop%0d: got %h want %h", i, sample_out, exp_sample(raw[i]));
      end
      step();
    end
    repeat (3) step();
    n_cmp++;
    if (sample_valid_out !== 1'b0 || fifo_level_out !== 4'd0) begin
      n_bad++; $display("FAIL overrun_drained: got valid %b level %0d want 0 0",
                        sample_valid_out, fifo_level_out);
    end
    sample_ready_in = 1'b0;
    status_clr_in = 1'b1;
    step();
    status_clr_in = 1'b0;
    n_cmp++;
    if (overrun_out !== 1'b0) begin
      n_bad++; $display("FAIL overrun_clear: got %b want 0", overrun_out);
    end
  endtask

  task automatic test_slow_xadc();
    bit ok;
    enable_in = 1'b1; sample_ready_in = 1'b0; drdy_never = 1'b0;
    eoc_delay = 150; drdy_delay = 2;
    do_reset();
    wait_evt(EV_DEN, 1, 3 * CLK_DIV, ok);
    n_cmp++;
    if (!ok || missed_tick_out !== 1'b1) begin
      n_bad++; $display("FAIL slow_missed_set: got %b want 1", missed_tick_out);
    end
    n_cmp++;
    if (convst_t.size() != 1) begin
      n_bad++; $display("FAIL slow_single_convst: got %0d want 1", convst_t.size());
    end
    wait_evt(EV_CONVST, 2, 2 * CLK_DIV, ok);
    n_cmp++;
    if (!ok || convst_t[1] - convst_t[0] != 2 * CLK_DIV) begin
      n_bad++; $display("FAIL slow_next_convst: got %0d want %0d", convst_t[1] - convst_t[0], 2 * CLK_DIV);
    end
    status_clr_in = 1'b1;
    step();
    status_clr_in = 1'b0;
    n_cmp++;
    if (missed_tick_out !== 1'b0) begin
      n_bad++; $display("FAIL slow_missed_clear: got %b want 0", missed_tick_out);
    end
    eoc_delay = 5;
  endtask

  task automatic test_drdy_timeout();
    bit ok;
    enable_in = 1'b1; sample_ready_in = 1'b0; drdy_never = 1'b1;
    eoc_delay = 5;
    do_reset();
    wait_evt(EV_TO, 1, 5 * CLK_DIV, ok);
    n_cmp++;
    if (!ok || to_t[0] - den_t[0] != TMO) begin
      n_bad++; $display("FAIL timeout_latency: got %0d want %0d", to_t[0] - den_t[0], TMO);
    end
    n_cmp++;
    if (timeout_out !== 1'b1 || fifo_level_out !== 4'd0) begin
      n_bad++; $display("FAIL timeout_no_push: got to %b level %0d want 1 0", timeout_out, fifo_level_out);
    end
    wait_evt(EV_CONVST, 2, 2 * CLK_DIV, ok);
    n_cmp++;
    if (!ok || convst_t[1] - convst_t[0] != 3 * CLK_DIV) begin
      n_bad++; $display("FAIL timeout_next_convst: got %0d want %0d", convst_t[1] - convst_t[0], 3 * CLK_DIV);
    end
    n_cmp++;
    if (missed_tick_out !== 1'b1) begin
      n_bad++; $display("FAIL timeout_missed: got %b want 1", missed_tick_out);
    end
    drdy_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    enable_in = 1'b1; sample_ready_in = 1'b0; drdy_never = 1'b0;
    eoc_delay = 5; drdy_delay = 2;
    do_reset();
    wait_evt(EV_VRISE, 1, 2 * CLK_DIV, ok);
    drdy_never = 1'b1;
    wait_evt(EV_DEN, 2, 2 * CLK_DIV, ok);
    repeat (10) step();
    n_cmp++;
    if (!ok || daddr_out !== 7'h10 || sample_valid_out !== 1'b1 || fifo_level_out !== 4'd1) begin
      n_bad++; $display("FAIL mid_pre_state: got addr %h valid %b level %0d want 10 1 1",
                        daddr_out, sample_valid_out, fifo_level_out);
    end
    #1 reset_n_in = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_bad++; $display("FAIL mid_async_reset: got %h want 0", all_outs);
    end
    drdy_never = 1'b0;
    do_reset();
    wait_evt(EV_CONVST, 1, 2 * CLK_DIV, ok);
    n_cmp++;
    if (!ok || convst_t[0] - rel_cyc != CLK_DIV) begin
      n_bad++; $display("FAIL mid_first_convst: got %0d want %0d", convst_t[0] - rel_cyc, CLK_DIV);
    end
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_codes();
    test_overrun();
    test_slow_xadc();
    test_drdy_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xadc_sampler.md
Name: xadc_sampler

Overview:
- Audio-rate sampling controller for the XADC primitive in event-driven, single-channel mode.
- Issues CONVST at a fixed sample rate and reads the conversion result over the DRP on EOC.
- Pushes 12-bit samples into a small FIFO that feeds the MFCC front-end through a valid/ready stream.
- Owns the DRP-master side of the XADC interface; replaces the ad-hoc CONVST/EOC wiring used in simulation.

Parameters:
CLK_DIV, 3125, dclk_in cycles per sample tick (50 MHz / 16 kHz); legal range 32..65535
FIFO_DEPTH, 8, sample FIFO entries; power of two, 2..64
DRDY_TIMEOUT, 255, maximum cycles to wait for drdy_in after den_out
SAMPLE_W, 12, sample width; the 12 MSBs of do_in

Ports:
dclk_in  in  1  clock (DRP clock, 50 MHz)
reset_n_in  in  1  asynchronous active-low reset
enable_in  in  1  run sampling; low = stop after any in-flight conversion
status_clr_in  in  1  one-cycle pulse; clears sticky flags
convst_out  out  1  conversion start to XADC, one-cycle pulse
busy_in  in  1  XADC busy_out
eoc_in  in  1  XADC eoc_out
channel_in  in  5  XADC channel_out
den_out  out  1  DRP enable, one-cycle pulse
dwe_out  out  1  DRP write enable, tied 0
daddr_out  out  7  DRP address
di_out  out  16  DRP write data, tied 0
drdy_in  in  1  DRP read ready
do_in  in  16  DRP read data
sample_out  out  SAMPLE_W  FIFO head sample
sample_valid_out  out  1  FIFO not empty
sample_ready_in  in  1  consumer accepts the head sample
fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overrun_out  out  1  sticky: sample dropped because FIFO was full
missed_tick_out  out  1  sticky: tick arrived while FSM was not in IDLE
timeout_out  out  1  sticky: drdy_in not received in time

Behaviour:
- Reset (asynchronous assert, synchronous release): every output 0, FSM in IDLE, divider 0, FIFO empty.
- Divider:
  - Counts 0..CLK_DIV-1 while enable_in=1; tick is one cycle at count CLK_DIV-1, then wraps to 0.
  - enable_in=0 holds the counter at 0 and produces no ticks.
- FSM states: IDLE, START, WAIT_EOC, READ, WAIT_DRDY.
  - IDLE: on tick with busy_in=0, go to START. A tick with busy_in=1 is discarded and sets missed_tick_out.
  - START: convst_out=1 for exactly this cycle, then go to WAIT_EOC.
  - WAIT_EOC: on eoc_in=1, latch daddr_out={2'b00, channel_in} and go to READ. No timeout in this state.
  - READ: den_out=1 for exactly this cycle; clear the timeout counter; go to WAIT_DRDY.
  - WAIT_DRDY:
    - On drdy_in, push do_in[15:16-SAMPLE_W] into the FIFO and return to IDLE.
    - If the counter reaches DRDY_TIMEOUT first, set timeout_out and return to IDLE with no push.
- A tick in any state other than IDLE sets missed_tick_out; the FSM does not change state.
- enable_in falling mid-conversion: the current sequence completes normally; no new tick follows.
- Latency: tick to convst_out = 1 cycle; eoc_in to den_out = 1 cycle; drdy_in to sample_valid_out (empty FIFO) = 1 cycle.
- FIFO:
  - First-word-fall-through; pop when sample_valid_out && sample_ready_in.
  - Push when full: sample dropped, overrun_out set. Simultaneous push and pop when full is accepted, no drop.
  - Pop when empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH; level is tracked separately.
- Sticky flags clear on status_clr_in. A flag set in the same cycle as status_clr_in remains set (set wins).
- dwe_out and di_out are constant 0.

Optional Feature:
XADC_SAMPLER_SIGNED_EN
- Defined: sample_out is two's complement, i.e. raw sample with its MSB inverted (0x800 reads as 0; 0xFFF reads as 0x7FF; 0x000 reads as 0x800). The conversion is applied at FIFO write.
- Undefined: sample_out is the raw unipolar offset-binary code.

Decomposition:
- Package xadc_sampler_pkg:
  - FSM state enum
  - DRP_ADDR_W=7, DRP_DATA_W=16
  - Status address constant VAUX0_ADDR=7'h10
  - Default CLK_DIV
- One sub-module, xadc_sample_fifo: parameterised FWFT FIFO with push, pop, full, empty, level and drop indication; instantiated once.
- Divider and FSM stay in the top level.

Test Plan:
- Basic conversion (CLK_DIV=100, behavioural XADC model returns channel_in=5'h10, do_in=16'hABC0): convst_out pulses once per 100 cycles; den_out pulses with daddr_out=7'h10; sample_out=12'hABC, sample_valid_out rises 1 cycle after drdy_in.
- Backpressure overrun: sample_ready_in=0 for 10 ticks with FIFO_DEPTH=8 → fifo_level_out=8; overrun_out=1 after the 9th sample; first 8 samples pop in order.
- Slow XADC: model delays eoc_in by 150 cycles with CLK_DIV=100 → missed_tick_out=1; no second convst_out until the FSM returns to IDLE; status_clr_in clears the flag.
- DRDY timeout: model never asserts drdy_in → timeout_out=1 exactly 255 cycles after den_out; FSM returns to IDLE; next tick issues convst_out.
- Reset mid-operation: assert reset_n_in=0 while in WAIT_DRDY → all outputs 0 immediately (asynchronous); after release, first convst_out occurs CLK_DIV cycles later.
- With XADC_SAMPLER_SIGNED_EN: do_in=16'h8000 → sample_out=12'h000; do_in=16'h0000 → 12'h800; do_in=16'hFFF0 → 12'h7FF.
